key_schedule_seq: RTL and testbench

- Sequential, parametrised key scheduler that replaces the combinational fixed 8-bit, 11-key generator.
- Expands one seed key into ROUNDS+1 round keys, one per cycle. Each key goes out on a valid/ready stream and is also stored in an internal table.
- Sits between the key-load interface and the round datapath of the cryptosystem. The round datapath either consumes the stream or reads the table by index.

---
 rtl/key_schedule_seq.sv | 128 ++++++++++++
 tb/tb_key_schedule_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// key_schedule_seq: expands one seed into ROUNDS+1 round keys, one per accepted
// handshake on a valid/ready stream, mirroring each key into a readable table.
`default_nettype none

module key_schedule_seq #(
  parameter int               WIDTH  = 8,
  parameter int               ROUNDS = 10,
  parameter int               ROT    = 1,
  parameter logic [WIDTH-1:0] POLY   = 8'h1B,
  localparam int              IDX_W  = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [WIDTH-1:0] rk_data,
  output logic [IDX_W-1:0] rk_idx,
  output logic             done,
  output logic             table_valid,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_key
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] rcon_q, rcon_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             tv_q, tv_d;
  logic             wr_en;
  logic [WIDTH-1:0] tbl_q [0:ROUNDS];
  logic [WIDTH-1:0] rotl;
  logic [WIDTH-1:0] rcon_dbl;

  assign rotl     = (cur_q << ROT) | (cur_q >> (WIDTH - ROT));
  // Carry-less doubling: shift out the MSB and fold it back in through POLY.
  assign rcon_dbl = {rcon_q[WIDTH-2:0], 1'b0} ^ (rcon_q[WIDTH-1] ? POLY : '0);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    tv_d    = tv_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = in_key;
          idx_d   = '0;
          rcon_d  = WIDTH'(1);
          tv_d    = 1'b0;
          state_d = GEN;
        end
      end
      GEN: begin
        if (rk_ready) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
            tv_d    = 1'b1;
          end else begin
            cur_d  = rotl ^ rcon_q;
            idx_d  = idx_q + 1'b1;
            rcon_d = rcon_dbl;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= WIDTH'(1);
      done_q  <= 1'b0;
      tv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
      tv_q    <= tv_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ROUNDS; i++) tbl_q[i] <= '0;
    end else if (wr_en) begin
      tbl_q[idx_q] <= cur_q;
    end
  end

  // Out-of-range read addresses fall through to zero.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= ROUNDS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_key = tbl_q[i];
    end
  end

  assign busy        = (state_q == GEN);
  assign rk_valid    = (state_q == GEN);
  assign rk_data     = cur_q;
  assign rk_idx      = idx_q;
  assign done        = done_q;
  assign table_valid = tv_q;

endmodule

`default_nettype wire

// File: tb/tb_key_schedule_seq.sv
// tb_key_schedule_seq: scoreboard bench for key_schedule_seq with an arithmetic
// reference model of the key/round-constant recurrence.
`default_nettype none

module tb_key_schedule_seq;

  localparam int W  = 8;
  localparam int R  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  in_key = '0;
  logic          busy, rk_valid, done, table_valid;
  logic          rk_ready = 1'b0;
  logic [W-1:0]  rk_data, rd_key;
  logic [IW-1:0] rk_idx;
  logic [IW-1:0] rd_idx = '0;

  key_schedule_seq #(.WIDTH(W), .ROUNDS(R), .ROT(1), .POLY(8'h1B)) dut (
    .clk(clk), .rst(rst), .start(start), .in_key(in_key),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .done(done),
    .table_valid(table_valid), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [IW+W-1:0]  sb[$];
  int               mk[0:R];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: rotate via multiply/divide, rcon doubled as an integer and
  // reduced by subtracting 256 and folding in 0x1B.
  task automatic build_model(input int seed);
    int k, r;
    logic [IW+W-1:0] e;
    k = seed % 256;
    r = 1;
    for (int i = 0; i <= R; i++) begin
      mk[i] = k;
      e = {IW'(i), W'(k)};
      sb.push_back(e);
      k = (((k * 2) % 256) + (k / 128)) ^ r;
      r = r * 2;
      if (r >= 256) r = (r - 256) ^ 'h1B;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i <= R; i++) mk[i] = 0;
  endtask

  task automatic check_table();
    for (int i = 0; i < 16; i++) begin
      rd_idx = IW'(i);
      #1;
      chk("rd_key", 32'(rd_key), (i <= R) ? mk[i] : 0);
    end
  endtask

  // Monitor: peek while valid (checks hold under backpressure), pop on handshake.
  always @(negedge clk) begin
    if (!rst && rk_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rk_unexpected: got idx %0d data %0h expected no key", rk_idx, rk_data);
      end else begin
        chk("rk_idx", 32'(rk_idx), 32'(sb[0][IW+W-1:W]));
        chk("rk_data", 32'(rk_data), 32'(sb[0][W-1:0]));
        if (rk_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic run(input int seed, input int bp_idx, input int bp_len,
                     input int inj_at, input int inj_key, input bit pre,
                     input bit chain, input int nseed, input bit rnd);
    int cyc, hs, stall, exp_done;
    bit got, injected;
    if (!pre) begin
      @(posedge clk); #1;
      start  = 1'b1;
      in_key = W'(seed);
    end
    build_model(seed);
    cyc = 0; hs = 0; stall = 0; exp_done = -1; got = 0; injected = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      start  = 1'b0;
      in_key = W'($urandom);
      if (hs == inj_at && !injected && exp_done < 0) begin
        injected = 1;
        start    = 1'b1;
        in_key   = W'(inj_key);
      end
      if (exp_done < 0) begin
        if (hs == bp_idx && stall < bp_len) begin
          rk_ready = 1'b0;
          stall++;
        end else begin
          rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rk_ready) begin
          hs++;
          if (hs == R + 1) exp_done = cyc + 1;
        end
      end else begin
        rk_ready = 1'($urandom);
      end
      if (chain && cyc == exp_done) begin
        start  = 1'b1;
        in_key = W'(nseed);
      end
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_rise", 32'(busy), 1);
        chk("tv_clear", 32'(table_valid), 0);
      end
      if (done) begin
        got = 1;
        chk("done_cycle", cyc, exp_done);
        chk("busy_at_done", 32'(busy), 0);
        chk("tv_at_done", 32'(table_valid), 1);
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
    end else if (!chain) begin
      repeat (3) begin
        @(negedge clk);
        chk("done_single", 32'(done), 0);
      end
      chk("sb_drained", sb.size(), 0);
      check_table();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(rk_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tv", 32'(table_valid), 0);
    chk("rst_data", 32'(rk_data), 0);
    chk("rst_idx", 32'(rk_idx), 0);
    clear_model();
    check_table();
    @(negedge clk);
    rst = 1'b0;

    // Seed 0x00 and 0xFF with full-rate ready
    run(0, -1, 0, -1, 0, 0, 0, 0, 0);
    rd_idx = 4'd9; #1;
    chk("rd_idx9_00", 32'(rd_key), 32'h1B);
    run(255, -1, 0, -1, 0, 0, 0, 0, 0);
    rd_idx = 4'd10; #1;
    chk("rd_idx10_ff", 32'(rd_key), 32'hFF);
    rd_idx = 4'd15; #1;
    chk("rd_idx15_ff", 32'(rd_key), 32'h00);

    // Backpressure for 3 cycles at idx 5
    run(0, 5, 3, -1, 0, 0, 0, 0, 0);
    // start pulsed mid-run is ignored
    run(0, -1, 0, 4, 'hAA, 0, 0, 0, 0);

    // Asynchronous reset mid-run at idx 6
    @(posedge clk); #1;
    start = 1'b1; in_key = 8'h00; rk_ready = 1'b1;
    build_model(0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_idx", 32'(rk_idx), 6);
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(rk_valid), 0);
    chk("midrst_tv", 32'(table_valid), 0);
    chk("midrst_done", 32'(done), 0);
    clear_model();
    check_table();
    @(negedge clk);
    rst = 1'b0;
    run(255, -1, 0, -1, 0, 0, 0, 0, 0);

    // Back-to-back: 0xFF run chained into a 0x00 run in the done cycle
    run(255, -1, 0, -1, 0, 0, 1, 0, 0);
    run(0, -1, 0, -1, 0, 1, 0, 0, 0);
    rd_idx = 4'd1; #1;
    chk("b2b_rd1", 32'(rd_key), 32'h01);

    // Randomized seeds, ready patterns, stalls and ignored starts
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run(int'($urandom_range(0, 255)), int'($urandom_range(0, R)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, R)),
          int'($urandom_range(0, 255)), 0, 0, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
